// File: rtl/lab_pkg.sv
// Shared VGA datapath types: pixel field widths, sequencer states and the circle job record.
package lab_pkg;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_FILL,
    SEQ_FILL_REL,
    SEQ_LOAD,
    SEQ_CIRC,
    SEQ_CIRC_REL,
    SEQ_DONE
  } seq_state_t;

  typedef struct packed {
    logic [X_W-1:0]      centre_x;
    logic [Y_W-1:0]      centre_y;
    logic [X_W-1:0]      radius;
    logic [COLOUR_W-1:0] colour;
  } draw_job_t;

endpackage

// File: rtl/draw_job_ram.sv
// Circle job table: synchronous write, combinational read, cleared asynchronously on reset.
module draw_job_ram
  import lab_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  draw_job_t     wdata,
  input  logic [AW-1:0] raddr,
  output draw_job_t     rdata
);

  draw_job_t mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/draw_sequencer.sv
// Drawing controller: sequences an optional fillscreen pass and a list of circle jobs,
// owning the VGA adapter pixel port and the upstream start/done handshake.
module draw_sequencer
  import lab_pkg::*;
#(
  parameter int unsigned MAX_JOBS = 4,
  parameter int unsigned JW       = $clog2(MAX_JOBS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                fill_en,
  input  logic [JW:0]         num_jobs,
  input  logic                cfg_we,
  input  logic [JW-1:0]       cfg_addr,
  input  logic [X_W-1:0]      cfg_centre_x,
  input  logic [Y_W-1:0]      cfg_centre_y,
  input  logic [X_W-1:0]      cfg_radius,
  input  logic [COLOUR_W-1:0] cfg_colour,
  output logic                busy,
  output logic                done,
  output logic                fill_start,
  input  logic                fill_done,
  input  logic [X_W-1:0]      fill_x,
  input  logic [Y_W-1:0]      fill_y,
  input  logic [COLOUR_W-1:0] fill_colour,
  input  logic                fill_plot,
  output logic                circ_start,
  input  logic                circ_done,
  output logic [X_W-1:0]      circ_centre_x,
  output logic [Y_W-1:0]      circ_centre_y,
  output logic [X_W-1:0]      circ_radius,
  output logic [COLOUR_W-1:0] circ_colour,
  input  logic [X_W-1:0]      circ_x,
  input  logic [Y_W-1:0]      circ_y,
  input  logic [COLOUR_W-1:0] circ_vcolour,
  input  logic                circ_plot,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam logic [JW:0] JOBS_MAX = (JW+1)'(MAX_JOBS);

  seq_state_t  state, state_nx;
  logic [JW:0] idx, idx_nx, jobs_q, jobs_clamped;
  logic        run_go, load_en, idx_inc;
  draw_job_t   job_wr, job_rd;

  assign jobs_clamped = (num_jobs > JOBS_MAX) ? JOBS_MAX : num_jobs;
  assign idx_nx       = idx + 1'b1;

  assign job_wr = '{centre_x: cfg_centre_x, centre_y: cfg_centre_y,
                    radius: cfg_radius, colour: cfg_colour};

  draw_job_ram #(
    .DEPTH(MAX_JOBS),
    .AW   (JW)
  ) u_job_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (cfg_we && !busy),
    .waddr(cfg_addr),
    .wdata(job_wr),
    .raddr(idx[JW-1:0]),
    .rdata(job_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SEQ_IDLE;
      idx    <= '0;
      jobs_q <= '0;
    end else begin
      state <= state_nx;
      if (run_go) begin
        idx    <= '0;
        jobs_q <= jobs_clamped;
      end else if (idx_inc) begin
        idx <= idx_nx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      circ_centre_x <= '0;
      circ_centre_y <= '0;
      circ_radius   <= '0;
      circ_colour   <= '0;
    end else if (load_en) begin
      circ_centre_x <= job_rd.centre_x;
      circ_centre_y <= job_rd.centre_y;
      circ_radius   <= job_rd.radius;
      circ_colour   <= job_rd.colour;
    end
  end

  // Handshake outputs decode straight from the state register, so reset drops them at once.
  always_comb begin
    state_nx   = state;
    run_go     = 1'b0;
    load_en    = 1'b0;
    idx_inc    = 1'b0;
    fill_start = 1'b0;
    circ_start = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      SEQ_IDLE: begin
        busy = 1'b0;
        if (start) begin
          run_go = 1'b1;
          if (fill_en)                 state_nx = SEQ_FILL;
          else if (jobs_clamped != '0) state_nx = SEQ_LOAD;
          else                         state_nx = SEQ_DONE;
        end
      end
      SEQ_FILL: begin
        fill_start = 1'b1;
        if (fill_done) state_nx = SEQ_FILL_REL;
      end
      SEQ_FILL_REL: begin
        if (!fill_done) state_nx = (jobs_q != '0) ? SEQ_LOAD : SEQ_DONE;
      end
      SEQ_LOAD: begin
        load_en  = 1'b1;
        state_nx = SEQ_CIRC;
      end
      SEQ_CIRC: begin
        circ_start = 1'b1;
        if (circ_done) state_nx = SEQ_CIRC_REL;
      end
      SEQ_CIRC_REL: begin
        if (!circ_done) begin
          idx_inc  = 1'b1;
          state_nx = (idx_nx == jobs_q) ? SEQ_DONE : SEQ_LOAD;
        end
      end
      SEQ_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (!start) state_nx = SEQ_IDLE;
      end
      default: state_nx = SEQ_IDLE;
    endcase
  end

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state)
      SEQ_FILL, SEQ_FILL_REL: begin
        vga_x      = fill_x;
        vga_y      = fill_y;
        vga_colour = fill_colour;
        vga_plot   = (state == SEQ_FILL) && fill_plot;
      end
      SEQ_LOAD, SEQ_CIRC, SEQ_CIRC_REL: begin
        vga_x      = circ_x;
        vga_y      = circ_y;
        vga_colour = circ_vcolour;
        vga_plot   = (state != SEQ_CIRC_REL) && circ_plot;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed and randomized runs of draw_sequencer against stub engines and a job-list model.
module tb_draw_sequencer;

  localparam int MAXJ = 4;
  localparam int JW   = 2;

  logic          clk = 1'b0;
  logic          rst, start, fill_en, cfg_we;
  logic [JW:0]   num_jobs;
  logic [JW-1:0] cfg_addr;
  logic [7:0]    cfg_centre_x, cfg_radius;
  logic [6:0]    cfg_centre_y;
  logic [2:0]    cfg_colour;
  logic          busy, done, fill_start, fill_done, fill_plot;
  logic [7:0]    fill_x;
  logic [6:0]    fill_y;
  logic [2:0]    fill_colour;
  logic          circ_start, circ_done, circ_plot;
  logic [7:0]    circ_centre_x, circ_radius, circ_x;
  logic [6:0]    circ_centre_y, circ_y;
  logic [2:0]    circ_colour, circ_vcolour;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [2:0]    vga_colour;
  logic          vga_plot;

  int n_cmp, n_bad;
  int flat, clat, fcnt, ccnt;
  logic [25:0] shadow [MAXJ];

  always #5 clk = ~clk;

  draw_sequencer #(.MAX_JOBS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .fill_en(fill_en), .num_jobs(num_jobs),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_centre_x(cfg_centre_x),
    .cfg_centre_y(cfg_centre_y), .cfg_radius(cfg_radius), .cfg_colour(cfg_colour),
    .busy(busy), .done(done),
    .fill_start(fill_start), .fill_done(fill_done), .fill_x(fill_x), .fill_y(fill_y),
    .fill_colour(fill_colour), .fill_plot(fill_plot),
    .circ_start(circ_start), .circ_done(circ_done), .circ_centre_x(circ_centre_x),
    .circ_centre_y(circ_centre_y), .circ_radius(circ_radius), .circ_colour(circ_colour),
    .circ_x(circ_x), .circ_y(circ_y), .circ_vcolour(circ_vcolour), .circ_plot(circ_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: stub engines react to the start levels, pixel streams are re-randomized,
  // then the adapter port is checked against whichever engine should own it.
  task automatic tick();
    logic fd_old, cd_old;
    @(posedge clk); #1;
    fd_old = fill_done;
    cd_old = circ_done;
    if (fill_start) begin fcnt++; if (fcnt >= flat) fill_done = 1'b1; end
    else begin fcnt = 0; fill_done = 1'b0; end
    if (circ_start) begin ccnt++; if (ccnt >= clat) circ_done = 1'b1; end
    else begin ccnt = 0; circ_done = 1'b0; end
    fill_x = 8'($urandom); fill_y = 7'($urandom); fill_colour = 3'($urandom);
    fill_plot = fill_start ? 1'($urandom) : fd_old;
    circ_x = 8'($urandom); circ_y = 7'($urandom); circ_vcolour = 3'($urandom);
    circ_plot = circ_start ? 1'($urandom) : cd_old;
    #1;
    if (fill_start)
      chk("mux_fill", 32'({vga_x, vga_y, vga_colour, vga_plot}),
          32'({fill_x, fill_y, fill_colour, fill_plot}));
    else if (circ_start)
      chk("mux_circ", 32'({vga_x, vga_y, vga_colour, vga_plot}),
          32'({circ_x, circ_y, circ_vcolour, circ_plot}));
    else if (!busy)
      chk("mux_idle", 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'(0));
    else
      chk("mux_gap_plot", 32'(vga_plot), 32'(0));
  endtask

  task automatic wr_job(input int i, input logic [25:0] v);
    cfg_we = 1'b1;
    cfg_addr = JW'(i);
    {cfg_centre_x, cfg_centre_y, cfg_radius, cfg_colour} = v;
    tick();
    cfg_we = 1'b0;
    shadow[i] = v;
  endtask

  task automatic do_run(input bit fe, input int nj, input int fl, input int cl,
                        input int wr_at, input bit drop, input int rst_at, input string tag);
    int n, fcyc, ncirc, cyc;
    bit prev_c, fin, aborted;
    logic [25:0] expq[$];
    logic [25:0] exp_p;
    n = (nj > MAXJ) ? MAXJ : nj;
    for (int i = 0; i < n; i++) expq.push_back(shadow[i]);
    flat = fl; clat = cl;
    fill_en = fe; num_jobs = nj[JW:0]; start = 1'b1;
    tick();
    if (fe)         chk({tag, "_lat_fill"}, 32'(fill_start), 32'(1));
    else if (n > 0) chk({tag, "_lat_load"}, 32'({busy, circ_start, fill_start}), 32'(4));
    else            chk({tag, "_lat_done"}, 32'({done, busy, circ_start}), 32'(4));
    fcyc = fill_start; ncirc = 0; cyc = 0; prev_c = 1'b0; aborted = 1'b0;
    fin = done;
    while (!fin && cyc < 4000) begin
      tick(); cyc++;
      cfg_we = 1'b0;
      if (fill_start) fcyc++;
      if (drop && fill_start) start = 1'b0;
      if (circ_start && !prev_c) begin
        ncirc++;
        if (expq.size() > 0) begin
          exp_p = expq.pop_front();
          chk({tag, "_circ_params"},
              32'({circ_centre_x, circ_centre_y, circ_radius, circ_colour}), 32'(exp_p));
        end
        if (ncirc == wr_at) begin
          cfg_we = 1'b1; cfg_addr = 1;
          {cfg_centre_x, cfg_centre_y, cfg_radius, cfg_colour} = 26'($urandom);
        end
        if (ncirc == rst_at) begin
          rst = 1'b1; #1;
          chk({tag, "_rst_outs"}, 32'({circ_start, fill_start, busy, vga_plot, done}), 32'(0));
          chk({tag, "_rst_params"},
              32'({circ_centre_x, circ_centre_y, circ_radius, circ_colour}), 32'(0));
          @(negedge clk);
          rst = 1'b0; start = 1'b0;
          fill_done = 1'b0; circ_done = 1'b0; fcnt = 0; ccnt = 0;
          for (int i = 0; i < MAXJ; i++) shadow[i] = '0;
          aborted = 1'b1;
        end
      end
      prev_c = circ_start;
      fin = done || aborted;
    end
    chk({tag, "_finished"}, 32'(fin), 32'(1));
    if (aborted) return;
    chk({tag, "_fill_cycles"}, fcyc, fe ? fl : 0);
    chk({tag, "_circles"}, ncirc, n);
    if (drop) begin
      tick();
      chk({tag, "_done_pulse"}, 32'({done, busy}), 32'(0));
    end else begin
      tick();
      chk({tag, "_done_held"}, 32'({done, busy}), 32'(2));
      start = 1'b0;
      tick();
      chk({tag, "_idle"}, 32'({done, busy}), 32'(0));
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; fill_en = 1'b0; num_jobs = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_centre_x = '0; cfg_centre_y = '0; cfg_radius = '0; cfg_colour = '0;
    fill_done = 1'b0; fill_x = '0; fill_y = '0; fill_colour = '0; fill_plot = 1'b0;
    circ_done = 1'b0; circ_x = '0; circ_y = '0; circ_vcolour = '0; circ_plot = 1'b0;
    flat = 1; clat = 1; fcnt = 0; ccnt = 0;
    for (int i = 0; i < MAXJ; i++) shadow[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'({busy, done, fill_start, circ_start, vga_plot, vga_x, vga_y, vga_colour}),
        32'(0));
    chk("reset_params", 32'({circ_centre_x, circ_centre_y, circ_radius, circ_colour}), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    wr_job(0, {8'd80, 7'd60, 8'd40, 3'd2});
    do_run(1'b1, 1, 100, 3, -1, 1'b0, -1, "fill_one");

    for (int i = 0; i < MAXJ; i++) wr_job(i, 26'($urandom));
    do_run(1'b0, 3, 1, $urandom_range(1, 5), -1, 1'b0, -1, "three_jobs");
    do_run(1'b0, 0, 1, 1, -1, 1'b0, -1, "empty");
    do_run(1'b0, 7, 1, 4, 1, 1'b0, -1, "clamp");

    do_run(1'b0, 4, 1, 3, -1, 1'b0, 2, "rst_mid");
    do_run(1'b0, 2, 1, 2, -1, 1'b0, -1, "after_rst");
    wr_job(0, 26'($urandom));
    wr_job(1, 26'($urandom));
    do_run(1'b0, 2, 1, 2, -1, 1'b0, -1, "restart");

    do_run(1'b1, 2, 5, 2, -1, 1'b1, -1, "start_drop");

    for (int r = 0; r < 6; r++) begin
      int nj;
      bit fe;
      for (int i = 0; i < MAXJ; i++) if ($urandom_range(0, 1) == 1) wr_job(i, 26'($urandom));
      fe = 1'($urandom);
      nj = $urandom_range(0, 7);
      do_run(fe, nj, $urandom_range(1, 6), $urandom_range(1, 6), -1,
             fe && ($urandom_range(0, 1) == 1), -1, "random");
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
